// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: special register indices and immediate-select encodings.
package decode_pkg;

    // Default register count. Parametrised blocks use the helper functions instead.
    localparam int unsigned NREGS_DEF = 16;
    localparam int unsigned LINK_IDX  = NREGS_DEF - 2;
    localparam int unsigned VEC_IDX   = NREGS_DEF - 1;

    typedef enum logic {
        SEL_EXT_IMM16 = 1'b0,
        SEL_EXT_IMM24 = 1'b1
    } sel_ext_e;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

    function automatic int unsigned link_idx(input int unsigned nregs);
        return nregs - 2;
    endfunction

    function automatic int unsigned vec_idx(input int unsigned nregs);
        return nregs - 1;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// Architectural register bank: two combinational read ports, scalar port C and vector-byte port V.
// Same-cycle write-to-read bypass is enabled by defining DECODE_BYPASS_EN.
module reg_bank
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned VEC_W  = 8,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_a,
    input  logic [AW-1:0]     ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic              we_c,
    input  logic [AW-1:0]     wa_c,
    input  logic [DATA_W-1:0] wd_c,
    input  logic              we_v,
    input  logic [VEC_W-1:0]  wd_v
);

    localparam logic [AW-1:0] VecAddr = AW'(vec_idx(NREGS));

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Port C is applied after port V so it wins on a collision at the vector register.
    always_comb begin
        regs_d = regs_q;
        if (we_v) begin
            regs_d[VecAddr] = {wd_v, {(DATA_W - VEC_W){1'b0}}};
        end
        if (we_c) begin
            regs_d[wa_c] = wd_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rd_a = regs_d[ra_a];
    assign rd_b = regs_d[ra_b];
`else
    assign rd_a = regs_q[ra_a];
    assign rd_b = regs_q[ra_b];
`endif

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage: address muxes, immediate extension, operand concatenation and a
// single valid/ready output register with flush. Optional bypass via DECODE_BYPASS_EN.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned VEC_W  = 8,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    sel_a,
    input  logic                    sel_b,
    input  logic                    sel_c,
    input  logic                    sel_ext,
    input  logic                    we_c,
    input  logic                    we_v,
    input  logic [DATA_W-1:0]       pc4_in,
    input  logic [AW-1:0]           rp,
    input  logic [AW-1:0]           rs,
    input  logic [AW-1:0]           rg_in,
    input  logic [AW-1:0]           rg_wb,
    input  logic [15:0]             imm16,
    input  logic [23:0]             imm24,
    input  logic [DATA_W-1:0]       din_c,
    input  logic [VEC_W-1:0]        din_v,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       pc4_out,
    output logic [AW-1:0]           rg_out,
    output logic [AW-1:0]           rp_out,
    output logic [AW-1:0]           rs_out,
    output logic [DATA_W-1:0]       do_a,
    output logic [DATA_W-1:0]       do_b,
    output logic [DATA_W-1:0]       imm_out,
    output logic [DATA_W+VEC_W-1:0] cat_out
);

    localparam logic [AW-1:0] LinkAddr = AW'(link_idx(NREGS));
    localparam logic [AW-1:0] VecAddr  = AW'(vec_idx(NREGS));

    logic [AW-1:0]           addr_a;
    logic [AW-1:0]           addr_b;
    logic [AW-1:0]           addr_c;
    logic [DATA_W-1:0]       rd_a;
    logic [DATA_W-1:0]       rd_b;
    logic [DATA_W-1:0]       imm_d;
    logic [DATA_W+VEC_W-1:0] cat_d;
    logic [25:0]             imm26;
    logic                    accept;

    out_state_e              state_q;
    logic [DATA_W-1:0]       pc4_q;
    logic [AW-1:0]           rg_q;
    logic [AW-1:0]           rp_q;
    logic [AW-1:0]           rs_q;
    logic [DATA_W-1:0]       do_a_q;
    logic [DATA_W-1:0]       do_b_q;
    logic [DATA_W-1:0]       imm_q;
    logic [DATA_W+VEC_W-1:0] cat_q;

    assign addr_a = sel_a ? LinkAddr : rp;
    assign addr_b = sel_b ? VecAddr : rs;
    assign addr_c = sel_c ? LinkAddr : rg_wb;

    reg_bank #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .VEC_W  (VEC_W)
    ) u_reg_bank (
        .clk  (clk),
        .rst  (rst),
        .ra_a (addr_a),
        .ra_b (addr_b),
        .rd_a (rd_a),
        .rd_b (rd_b),
        .we_c (we_c),
        .wa_c (addr_c),
        .wd_c (din_c),
        .we_v (we_v),
        .wd_v (din_v)
    );

    assign imm26 = {imm24, 2'b00};

    always_comb begin
        imm_d = DATA_W'($signed(imm16));
        if (sel_ext_e'(sel_ext) == SEL_EXT_IMM24) begin
            imm_d = DATA_W'($signed(imm26));
        end
    end

    assign cat_d = {rd_a, rd_b[DATA_W-1 -: VEC_W]};

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Flush beats accept; writes into the bank are unaffected by either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            pc4_q   <= '0;
            rg_q    <= '0;
            rp_q    <= '0;
            rs_q    <= '0;
            do_a_q  <= '0;
            do_b_q  <= '0;
            imm_q   <= '0;
            cat_q   <= '0;
        end else if (flush) begin
            state_q <= StEmpty;
        end else if (accept) begin
            state_q <= StFull;
            pc4_q   <= pc4_in;
            rg_q    <= rg_in;
            rp_q    <= rp;
            rs_q    <= rs;
            do_a_q  <= rd_a;
            do_b_q  <= rd_b;
            imm_q   <= imm_d;
            cat_q   <= cat_d;
        end else if (out_ready) begin
            state_q <= StEmpty;
        end
    end

    assign pc4_out = pc4_q;
    assign rg_out  = rg_q;
    assign rp_out  = rp_q;
    assign rs_out  = rs_q;
    assign do_a    = do_a_q;
    assign do_b    = do_b_q;
    assign imm_out = imm_q;
    assign cat_out = cat_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe with hand-computed expectations; honours DECODE_BYPASS_EN.
module tb_decode_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned VEC_W  = 8;
    localparam int unsigned AW     = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic                    sel_a;
    logic                    sel_b;
    logic                    sel_c;
    logic                    sel_ext;
    logic                    we_c;
    logic                    we_v;
    logic [DATA_W-1:0]       pc4_in;
    logic [AW-1:0]           rp;
    logic [AW-1:0]           rs;
    logic [AW-1:0]           rg_in;
    logic [AW-1:0]           rg_wb;
    logic [15:0]             imm16;
    logic [23:0]             imm24;
    logic [DATA_W-1:0]       din_c;
    logic [VEC_W-1:0]        din_v;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       pc4_out;
    logic [AW-1:0]           rg_out;
    logic [AW-1:0]           rp_out;
    logic [AW-1:0]           rs_out;
    logic [DATA_W-1:0]       do_a;
    logic [DATA_W-1:0]       do_b;
    logic [DATA_W-1:0]       imm_out;
    logic [DATA_W+VEC_W-1:0] cat_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    decode_pipe #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .VEC_W  (VEC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_c     (sel_c),
        .sel_ext   (sel_ext),
        .we_c      (we_c),
        .we_v      (we_v),
        .pc4_in    (pc4_in),
        .rp        (rp),
        .rs        (rs),
        .rg_in     (rg_in),
        .rg_wb     (rg_wb),
        .imm16     (imm16),
        .imm24     (imm24),
        .din_c     (din_c),
        .din_v     (din_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc4_out   (pc4_out),
        .rg_out    (rg_out),
        .rp_out    (rp_out),
        .rs_out    (rs_out),
        .do_a      (do_a),
        .do_b      (do_b),
        .imm_out   (imm_out),
        .cat_out   (cat_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] exp_bypass;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0; sel_ext = 1'b0;
        we_c = 1'b0; we_v = 1'b0;
        pc4_in = '0; rp = '0; rs = '0; rg_in = '0; rg_wb = '0;
        imm16 = '0; imm24 = '0; din_c = '0; din_v = '0;

        repeat (2) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_do_a",      64'(do_a),      64'd0);
        check("rst_imm",       64'(imm_out),   64'd0);
        check("rst_cat",       64'(cat_out),   64'd0);
        check("rst_pc4",       64'(pc4_out),   64'd0);
        rst = 1'b0;
        tick();

        // Write reg3, then read it through port A.
        we_c = 1'b1; rg_wb = 4'd3; din_c = 32'hDEADBEEF;
        tick();
        we_c = 1'b0;
        in_valid = 1'b1; rp = 4'd3; rs = 4'd0; rg_in = 4'd7; pc4_in = 32'h104; imm16 = 16'h7FFF;
        tick();
        in_valid = 1'b0;
        check("wb_out_valid", 64'(out_valid), 64'd1);
        check("wb_do_a",      64'(do_a),      64'hDEADBEEF);
        check("wb_do_b",      64'(do_b),      64'd0);
        check("imm16_pos",    64'(imm_out),   64'h00007FFF);
        check("wb_pc4",       64'(pc4_out),   64'h104);
        check("wb_rg",        64'(rg_out),    64'd7);
        check("wb_rp",        64'(rp_out),    64'd3);
        check("wb_cat",       64'(cat_out),   64'hDEADBEEF00);
        tick();
        check("drain_valid",  64'(out_valid), 64'd0);

        // 24-bit immediate, shifted and sign-extended from bit 25.
        in_valid = 1'b1; sel_ext = 1'b1; imm24 = 24'h800001;
        tick();
        in_valid = 1'b0; sel_ext = 1'b0;
        check("imm24_neg", 64'(imm_out), 64'hFE000004);
        tick();

        // Port C and V collide on reg15: C wins.
        we_v = 1'b1; din_v = 8'hA5; we_c = 1'b1; sel_c = 1'b0; rg_wb = 4'd15; din_c = 32'h1;
        tick();
        we_v = 1'b0; we_c = 1'b0;
        in_valid = 1'b1; sel_b = 1'b1;
        tick();
        in_valid = 1'b0;
        check("cv_prio_do_b", 64'(do_b), 64'h1);
        check("cv_prio_cat",  64'(cat_out[7:0]), 64'h00);
        tick();

        // Port V alone.
        we_v = 1'b1; din_v = 8'hA5;
        tick();
        we_v = 1'b0;
        in_valid = 1'b1; sel_b = 1'b1;
        tick();
        in_valid = 1'b0; sel_b = 1'b0;
        check("vec_do_b",  64'(do_b), 64'hA5000000);
        check("vec_cat",   64'(cat_out[7:0]), 64'hA5);
        tick();

        // Stall: capture one instruction, then hold for 3 cycles while a write hits reg3.
        in_valid = 1'b1; rp = 4'd3; rs = 4'd15; pc4_in = 32'h200;
        tick();
        out_ready = 1'b0; pc4_in = 32'h300; rp = 4'd0;
        we_c = 1'b1; rg_wb = 4'd3; din_c = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            we_c = 1'b0;
            check("stall_in_ready", 64'(in_ready),  64'd0);
            check("stall_valid",    64'(out_valid), 64'd1);
            check("stall_pc4",      64'(pc4_out),   64'h200);
            check("stall_do_a",     64'(do_a),      64'hDEADBEEF);
        end
        out_ready = 1'b1;
        tick();
        check("unstall_pc4",  64'(pc4_out), 64'h300);
        check("unstall_do_a", 64'(do_a),    64'd0);
        rp = 4'd3; pc4_in = 32'h400;
        tick();
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_do_a",  64'(do_a),      64'h12345678);

        // Flush while full with in_valid high; the flush-cycle write to reg5 still lands.
        pc4_in = 32'h500; flush = 1'b1; we_c = 1'b1; rg_wb = 4'd5; din_c = 32'h99;
        tick();
        flush = 1'b0; we_c = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        tick();
        check("flush_gone_valid", 64'(out_valid), 64'd0);
        check("flush_gone_pc4",   64'(pc4_out),   64'h400);

        // Same-cycle write and read of reg5.
        in_valid = 1'b1; rs = 4'd5; we_c = 1'b1; rg_wb = 4'd5; din_c = 32'h55;
`ifdef DECODE_BYPASS_EN
        exp_bypass = 32'h55;
`else
        exp_bypass = 32'h99;
`endif
        tick();
        we_c = 1'b0;
        check("bypass_do_b", 64'(do_b), 64'(exp_bypass));
        tick();
        check("after_wr_do_b", 64'(do_b), 64'h55);

        // Reset in the middle of a stall drops everything.
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_valid",    64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready),  64'd1);
        check("midrst_do_a",     64'(do_a),      64'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; rp = 4'd3;
        tick();
        in_valid = 1'b0;
        check("midrst_reg3", 64'(do_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised, registered decode stage for the image-filter processor. It sits between fetch and execute and holds the architectural register bank, with two read ports, a scalar write-back port and a vector-byte write port. It produces the operand, immediate and 40-bit concatenation outputs, then captures them in a single valid/ready pipeline register with flush. Compared with the purely combinational decode it supports configurable widths and depths, stall/flush handshaking and optional same-cycle write-to-read bypass.

## Interface
Parameters:
- DATA_W, 32, register/operand width (≥ 26)
- NREGS, 16, register count, power of two ≥ 4
- VEC_W, 8, vector byte width (< DATA_W)

Ports (AW = $clog2(NREGS)):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- flush  in  1  kill stage contents
- sel_a, sel_b, sel_c, sel_ext  in  1 each  address/immediate selects
- we_c, we_v  in  1 each  write enables
- pc4_in  in  DATA_W  PC+4
- rp, rs, rg_in, rg_wb  in  AW each  source, destination and write-back addresses
- imm16  in  16
- imm24  in  24
- din_c  in  DATA_W  write-back data
- din_v  in  VEC_W  vector byte
- out_valid  out  1
- out_ready  in  1
- pc4_out  out  DATA_W
- rg_out, rp_out, rs_out  out  AW each
- do_a, do_b  out  DATA_W each
- imm_out  out  DATA_W
- cat_out  out  DATA_W+VEC_W  {do_a, do_b[DATA_W-1 -: VEC_W]}

## Operation
- Read address A = sel_a ? NREGS-2 : rp. Read address B = sel_b ? NREGS-1 : rs.
- Write address C = sel_c ? NREGS-2 : rg_wb.
- Port C writes din_c to address C when we_c is high.
- Port V writes {din_v, zeros} to register NREGS-1 when we_v is high.
- If both ports target NREGS-1 in the same cycle, port C wins.
- Writes happen every cycle, independent of the handshake, stall or flush.
- Immediate:
  - sel_ext=0: imm16 sign-extended to DATA_W.
  - sel_ext=1: {imm24, 2'b00} sign-extended from bit 25 to DATA_W.
- Accept = in_valid && in_ready. On accept, the output register captures read data, imm, cat, pc4_in, rg_in, rp and rs, and out_valid is set.
- in_ready = !out_valid || out_ready (combinational; no skid buffer).
- Stall (out_valid && !out_ready): all outputs hold unchanged. Writes to registers already captured in the output register do not update it.
- Output register states:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on out_ready && !in_valid.
  - FULL → FULL when out_ready && in_valid (back-to-back capture).
- flush has priority over everything:
  - next cycle out_valid=0;
  - any accept in the flush cycle is discarded;
  - register writes still occur.

## Timing
- Latency: 1 cycle from accept to out_valid; throughput 1 per cycle when out_ready stays high.
- Register writes take effect at the clock edge. With bypass (see Configuration), a same-cycle read sees the new value.
- Reset (asynchronous):
  - all NREGS registers = 0;
  - out_valid = 0;
  - pc4_out, rg_out, rp_out, rs_out, do_a, do_b, imm_out, cat_out = 0.
  - in_ready = 1 after reset.
- Reset asserted mid-stall drops the held instruction; no partial state survives.

## Configuration
- DECODE_BYPASS_EN defined:
  - if an accept reads an address that port C or port V writes in the same cycle, the captured operand is the newly written value;
  - C/V priority applies to the bypass.
- Undefined: the captured operand is the pre-write contents, and the new value is visible from the next accept.

## Structure
- Package decode_pkg: localparams LINK_IDX (NREGS-2), VEC_IDX (NREGS-1), and SEL_EXT_IMM16 / SEL_EXT_IMM24 encodings.
- Sub-module reg_bank: NREGS×DATA_W storage, 2 combinational read ports, ports C and V, C-over-V priority, bypass under DECODE_BYPASS_EN.
- Top level: address muxes, immediate extender, concatenation, output register.

## Test plan
- Reset, then we_c=1, rg_wb=3, din_c=0xDEADBEEF; next cycle rp=3, in_valid=1 → one cycle later out_valid=1, do_a=0xDEADBEEF.
- sel_ext=1, imm24=0x800001 → imm_out=0xFE000004. sel_ext=0, imm16=0x7FFF → imm_out=0x00007FFF.
- we_v=1, din_v=0xA5 with we_c=1, sel_c=0, rg_wb=15, din_c=0x1 in the same cycle → reg15=0x1. we_v alone → reg15=0xA5000000, and cat_out low byte=0xA5 when read via sel_b=1.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged; out_ready=1 → next instruction is captured on that edge.
- flush during FULL with in_valid=1 → out_valid=0 next cycle; the flushed-cycle instruction never appears.
- With DECODE_BYPASS_EN, write reg5=0x55 and read rs=5 in the same accept cycle → do_b=0x55. Without the macro → do_b = old value.
